// File: rtl/perceptron_window_activation_if.sv
// rtl/perceptron_window_activation_if.sv - sample input and decision output handshakes
interface perceptron_window_activation_if;
    logic [3:0] sum_in;
    logic       sum_valid;
    logic       sum_ready;
    logic [7:0] acc_out;
    logic       fire;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output sum_in, sum_valid, out_ready,
        input  sum_ready, acc_out, fire, out_valid
    );

    modport slave (
        input  sum_in, sum_valid, out_ready,
        output sum_ready, acc_out, fire, out_valid
    );
endinterface

// File: rtl/perceptron_window_activation.sv
// rtl/perceptron_window_activation.sv - saturating window accumulator with threshold decision
module perceptron_window_activation #(
    parameter int                 WINDOW      = 4,
    parameter logic signed [7:0]  THRESH_INIT = 8'sd0
) (
    input  logic                            clk,
    input  logic                            reset,
    perceptron_window_activation_if.slave   bus,
    input  logic [7:0]                      thresh_in,
    input  logic                            thresh_load,
    output logic                            busy
);
    localparam int              CW  = $clog2(WINDOW + 1);
    localparam logic [CW-1:0]   WIN = CW'(WINDOW);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t             state;
    logic signed [7:0]  acc;
    logic signed [7:0]  threshold;
    logic signed [7:0]  acc_out_r;
    logic               fire_r;
    logic               out_valid_r;
    logic [CW-1:0]      count;

    logic               accept;
    logic               last;
    logic [7:0]         base;
    logic [8:0]         wide;
    logic signed [7:0]  next_acc;

    // A new window starts from zero, so IDLE simply uses a zero base.
    always_comb begin
        accept = bus.sum_valid && (state != OUT);
        base   = (state == IDLE) ? 8'h00 : acc;
        wide   = {base[7], base} + {{5{bus.sum_in[3]}}, bus.sum_in};
        if (wide[8] != wide[7]) begin
            next_acc = wide[8] ? 8'sh80 : 8'sh7f;
        end else begin
            next_acc = wide[7:0];
        end
        last = (count + CW'(1)) == WIN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            count       <= '0;
            threshold   <= THRESH_INIT;
            acc_out_r   <= '0;
            fire_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (thresh_load) begin
                threshold <= thresh_in;
            end
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc   <= next_acc;
                        count <= count + CW'(1);
                        // Compare sees the pre-edge threshold even if a load lands now.
                        if (last) begin
                            acc_out_r   <= next_acc;
                            fire_r      <= next_acc >= threshold;
                            out_valid_r <= 1'b1;
                            state       <= OUT;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        acc         <= '0;
                        count       <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sum_ready = (state != OUT);
    assign bus.acc_out   = acc_out_r;
    assign bus.fire      = fire_r;
    assign bus.out_valid = out_valid_r;
    assign busy          = (state == ACCUM) || (state == OUT);
endmodule

// File: tb/tb_perceptron_window_activation.sv
// tb/tb_perceptron_window_activation.sv - scoreboard bench for the window activation stage
module tb_perceptron_window_activation;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] th_in;
    logic       load4, load64;
    logic       busy4, busy64;

    perceptron_window_activation_if b4();
    perceptron_window_activation_if b64();

    perceptron_window_activation #(.WINDOW(4), .THRESH_INIT(8'sd0)) u4 (
        .clk(clk), .reset(reset), .bus(b4),
        .thresh_in(th_in), .thresh_load(load4), .busy(busy4)
    );

    perceptron_window_activation #(.WINDOW(64), .THRESH_INIT(8'sd0)) u64 (
        .clk(clk), .reset(reset), .bus(b64),
        .thresh_in(th_in), .thresh_load(load64), .busy(busy64)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc;
        bit fire;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;
    bit   sel    = 1'b0;
    int   model_th[2];
    int   model_acc = 0;
    int   stim[$];
    bit   load_on_last = 1'b0;
    int   load_val = 0;

    function automatic int clamp8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic logic rd_ready();
        return sel ? b64.sum_ready : b4.sum_ready;
    endfunction
    function automatic logic rd_valid();
        return sel ? b64.out_valid : b4.out_valid;
    endfunction
    function automatic logic rd_fire();
        return sel ? b64.fire : b4.fire;
    endfunction
    function automatic logic rd_busy();
        return sel ? busy64 : busy4;
    endfunction
    function automatic int rd_acc();
        logic signed [7:0] a;
        a = sel ? b64.acc_out : b4.acc_out;
        return int'(a);
    endfunction

    task automatic set_valid(input logic v);
        if (sel) b64.sum_valid = v; else b4.sum_valid = v;
    endtask
    task automatic set_in(input int v);
        logic [3:0] t;
        t = v[3:0];
        if (sel) b64.sum_in = t; else b4.sum_in = t;
    endtask
    task automatic set_oready(input logic v);
        if (sel) b64.out_ready = v; else b4.out_ready = v;
    endtask
    task automatic set_load(input logic v);
        if (sel) load64 = v; else load4 = v;
    endtask

    task automatic load_thresh(input int v);
        th_in = 8'(v);
        set_load(1'b1);
        @(negedge clk);
        set_load(1'b0);
        model_th[sel] = v;
    endtask

    task automatic send(input int v);
        int n = 0;
        set_in(v);
        set_valid(1'b1);
        while (rd_ready() !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            total++;
            $display("FAIL send_timeout sum_ready=%b required=1", rd_ready());
        end
        @(negedge clk);
        set_valid(1'b0);
    endtask

    task automatic feed_window();
        exp_t e;
        for (int i = 0; i < stim.size(); i++) begin
            model_acc = clamp8(model_acc + stim[i]);
            if (i == stim.size() - 1) begin
                e.acc  = model_acc;
                e.fire = (model_acc >= model_th[sel]);
                exp_q.push_back(e);
                if (load_on_last) begin
                    th_in = 8'(load_val);
                    set_load(1'b1);
                end
            end
            send(stim[i]);
        end
        if (load_on_last) begin
            set_load(1'b0);
            model_th[sel] = load_val;
            load_on_last  = 1'b0;
        end
        model_acc = 0;
        total++;
        if (rd_valid() !== 1'b1) $display("FAIL decision_latency out_valid=%b required=1", rd_valid());
        else passed++;
    endtask

    task automatic recv();
        int   n = 0;
        exp_t e;
        while (rd_valid() !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            total++;
            $display("FAIL recv_timeout out_valid=%b required=1", rd_valid());
        end
        if (exp_q.size() == 0) begin
            total++;
            $display("FAIL scoreboard_empty entries=0 required=1");
            return;
        end
        e = exp_q.pop_front();
        total++;
        if (rd_acc() !== e.acc) $display("FAIL acc_out got=%0d required=%0d", rd_acc(), e.acc);
        else passed++;
        total++;
        if (rd_fire() !== e.fire) $display("FAIL fire got=%b required=%b (acc=%0d)", rd_fire(), e.fire, e.acc);
        else passed++;
        set_oready(1'b1);
        @(negedge clk);
        set_oready(1'b0);
        total++;
        if (rd_valid() !== 1'b0 || rd_ready() !== 1'b1)
            $display("FAIL out_handshake out_valid=%b sum_ready=%b required 0/1", rd_valid(), rd_ready());
        else passed++;
        total++;
        if (rd_acc() !== e.acc) $display("FAIL acc_out_hold got=%0d required=%0d", rd_acc(), e.acc);
        else passed++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_th[0] = 0;
        model_th[1] = 0;
        model_acc   = 0;
        exp_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        total++;
        if (b4.out_valid !== 1'b0 || b4.acc_out !== 8'h00 || b4.fire !== 1'b0 ||
            busy4 !== 1'b0 || b4.sum_ready !== 1'b1)
            $display("FAIL %s ov=%b acc=%h fire=%b busy=%b rdy=%b required 0/00/0/0/1",
                     tag, b4.out_valid, b4.acc_out, b4.fire, busy4, b4.sum_ready);
        else passed++;
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_state("reset_state");
    endtask

    task automatic test_basic();
        sel = 1'b0;
        stim = '{1, 2, -1, 3};
        total++;
        if (b4.out_valid !== 1'b0) $display("FAIL basic_idle out_valid=%b required=0", b4.out_valid);
        else passed++;
        feed_window();
        total++;
        if (b4.sum_ready !== 1'b0 || busy4 !== 1'b1)
            $display("FAIL basic_out sum_ready=%b busy=%b required 0/1", b4.sum_ready, busy4);
        else passed++;
        recv();
    endtask

    task automatic test_threshold();
        sel = 1'b0;
        load_thresh(6);
        stim = '{1, 2, -1, 3};
        feed_window();
        load_thresh(5);
        total++;
        if (b4.fire !== 1'b0) $display("FAIL fire_stable_in_out got=%b required=0", b4.fire);
        else passed++;
        recv();
        stim = '{2, 2, 2, 2};
        feed_window();
        recv();
    endtask

    task automatic test_saturation();
        sel = 1'b1;
        stim.delete();
        for (int i = 0; i < 64; i++) stim.push_back(7);
        feed_window();
        recv();
        load_thresh(-128);
        stim.delete();
        for (int i = 0; i < 64; i++) stim.push_back(-8);
        feed_window();
        recv();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sel = 1'b0;
        stim = '{1, 1, 1, 1};
        feed_window();
        e = exp_q.pop_front();
        set_in(3);
        set_valid(1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (b4.sum_ready !== 1'b0 || b4.out_valid !== 1'b1 || rd_acc() !== e.acc)
                $display("FAIL backpressure cyc=%0d rdy=%b ov=%b acc=%0d required 0/1/%0d",
                         i, b4.sum_ready, b4.out_valid, rd_acc(), e.acc);
            else passed++;
        end
        total++;
        if (b4.fire !== e.fire) $display("FAIL backpressure_fire got=%b required=%b", b4.fire, e.fire);
        else passed++;
        set_oready(1'b1);
        @(negedge clk);
        set_oready(1'b0);
        total++;
        if (b4.out_valid !== 1'b0 || b4.sum_ready !== 1'b1 || busy4 !== 1'b0)
            $display("FAIL release ov=%b rdy=%b busy=%b required 0/1/0", b4.out_valid, b4.sum_ready, busy4);
        else passed++;
        @(negedge clk);
        set_valid(1'b0);
        total++;
        if (busy4 !== 1'b1) $display("FAIL accept_after_release busy=%b required=1", busy4);
        else passed++;
        model_acc = 3;
        stim = '{1, 1, 1};
        feed_window();
        recv();
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        send(5);
        send(6);
        do_reset();
        check_reset_state("reset_mid_window");
        stim = '{2, -3, 4, 1};
        feed_window();
        recv();
    endtask

    task automatic test_thresh_on_last();
        sel = 1'b0;
        load_thresh(1);
        stim = '{1, 1, -1, 1};
        load_on_last = 1'b1;
        load_val = 3;
        feed_window();
        recv();
        stim = '{1, 1, 1, -1};
        feed_window();
        recv();
    endtask

    initial begin
        reset = 1'b1;
        th_in = 8'h00;
        load4 = 1'b0;
        load64 = 1'b0;
        b4.sum_in = 4'h0;  b4.sum_valid = 1'b0;  b4.out_ready = 1'b0;
        b64.sum_in = 4'h0; b64.sum_valid = 1'b0; b64.out_ready = 1'b0;
        model_th[0] = 0;
        model_th[1] = 0;
        test_reset();
        test_basic();
        test_threshold();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_thresh_on_last();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
